// File: rtl/zanagotchi_pkg.sv
// Shared Zanagotchi definitions: pet state codes, attribute limits and saturating helpers.
package zanagotchi_pkg;

  localparam logic [3:0] EST_PARADO    = 4'd0;
  localparam logic [3:0] EST_COMENDO   = 4'd1;
  localparam logic [3:0] EST_BRINCANDO = 4'd2;
  localparam logic [3:0] EST_DORMINDO  = 4'd3;
  localparam logic [3:0] EST_MORTO     = 4'd4;

  localparam logic [7:0] FOME_INI  = 8'h40;
  localparam logic [7:0] FELIC_INI = 8'hC0;
  localparam logic [7:0] SONO_INI  = 8'h40;

  localparam logic [7:0] ATR_MAX = 8'd255;
  localparam logic [7:0] ATR_MIN = 8'd0;

  // The 9th bit of the intermediate flags overflow (add) or borrow (sub).
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] d);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, d};
    return s[8] ? ATR_MAX : s[7:0];
  endfunction

  function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] d);
    logic [8:0] s;
    s = {1'b0, a} - {1'b0, d};
    return s[8] ? ATR_MIN : s[7:0];
  endfunction

endpackage

// File: rtl/divisor_tick.sv
// Free-running prescaler: one-cycle tick every DIV clocks, first tick DIV cycles after reset.
module divisor_tick #(
  parameter int unsigned DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] CNT_MAX = W'(DIV - 1);

  logic [W-1:0] cnt_r;

  assign tick = (cnt_r == CNT_MAX);

  // Count 0..DIV-1 and wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {W{1'b0}};
    end else if (tick) begin
      cnt_r <= {W{1'b0}};
    end else begin
      cnt_r <= cnt_r + W'(1);
    end
  end

endmodule

// File: rtl/controlador_vitais.sv
// Vital-sign engine: per-tick saturating update of hunger, happiness and tiredness, sticky death.
module controlador_vitais
  import zanagotchi_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 25_000_000,
  parameter int unsigned PASSO_LENTO  = 1,
  parameter int unsigned PASSO_RAPIDO = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] estado,
  output logic [7:0] fome,
  output logic [7:0] felicidade,
  output logic [7:0] sono,
  output logic       morreu
);

  localparam logic [7:0] PASSO_L = 8'(PASSO_LENTO);
  localparam logic [7:0] PASSO_R = 8'(PASSO_RAPIDO);

  logic       tick_s;
  logic [7:0] fome_nxt_s;
  logic [7:0] felic_nxt_s;
  logic [7:0] sono_nxt_s;
  logic       fatal_s;
  logic       morreu_nxt_s;

  divisor_tick #(.DIV(TICK_DIV)) u_divisor_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick_s)
  );

  // Next attribute values; estado only matters in a live tick cycle. 2L is two chained saturating steps.
  always_comb begin
    fome_nxt_s  = fome;
    felic_nxt_s = felicidade;
    sono_nxt_s  = sono;
    if (tick_s && !morreu) begin
      case (estado)
        EST_COMENDO: begin
          fome_nxt_s = sat_sub(fome, PASSO_R);
          sono_nxt_s = sat_add(sono, PASSO_L);
        end
        EST_BRINCANDO: begin
          fome_nxt_s  = sat_add(sat_add(fome, PASSO_L), PASSO_L);
          felic_nxt_s = sat_add(felicidade, PASSO_R);
          sono_nxt_s  = sat_add(sat_add(sono, PASSO_L), PASSO_L);
        end
        EST_DORMINDO: begin
          fome_nxt_s = sat_add(fome, PASSO_L);
          sono_nxt_s = sat_sub(sono, PASSO_R);
        end
        EST_MORTO: begin
          fome_nxt_s = fome;
        end
        default: begin
          fome_nxt_s  = sat_add(fome, PASSO_L);
          felic_nxt_s = sat_sub(felicidade, PASSO_L);
          sono_nxt_s  = sat_add(sono, PASSO_L);
        end
      endcase
    end else begin
      fome_nxt_s = fome;
    end
  end

  assign fatal_s      = (fome_nxt_s == ATR_MAX) || (felic_nxt_s == ATR_MIN) || (sono_nxt_s == ATR_MAX);
  assign morreu_nxt_s = morreu || (tick_s && fatal_s);

  // Attribute and death registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fome       <= FOME_INI;
      felicidade <= FELIC_INI;
      sono       <= SONO_INI;
      morreu     <= 1'b0;
    end else begin
      fome       <= fome_nxt_s;
      felicidade <= felic_nxt_s;
      sono       <= sono_nxt_s;
      morreu     <= morreu_nxt_s;
    end
  end

endmodule

// File: tb/tb_controlador_vitais.sv
// Directed bench for controlador_vitais with TICK_DIV=4, L=1, R=8.
module tb_controlador_vitais;

  logic       clk;
  logic       rst_n;
  logic [3:0] estado;
  logic [7:0] fome;
  logic [7:0] felicidade;
  logic [7:0] sono;
  logic       morreu;

  int total;
  int bad;

  controlador_vitais #(
    .TICK_DIV     (4),
    .PASSO_LENTO  (1),
    .PASSO_RAPIDO (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .estado     (estado),
    .fome       (fome),
    .felicidade (felicidade),
    .sono       (sono),
    .morreu     (morreu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Restart from reset; leaves us on a negedge with the prescaler at 0.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Advance n whole tick periods, ending on a negedge after the update.
  task automatic run_ticks(input int n);
    repeat (4 * n) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [24:0] exp_v;
    estado = 4'd0;
    do_reset();
    run_ticks(2);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    exp_v = {8'h40, 8'hC0, 8'h40, 1'b0};
    total++;
    if ({fome, felicidade, sono, morreu} !== exp_v) begin
      bad++;
      $display("FAIL reset_immediate got=%h want=%h", {fome, felicidade, sono, morreu}, exp_v);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({fome, felicidade, sono, morreu} !== exp_v) begin
      bad++;
      $display("FAIL reset_no_early_tick got=%h want=%h", {fome, felicidade, sono, morreu}, exp_v);
    end
    @(negedge clk);
    exp_v = {8'h41, 8'hBF, 8'h41, 1'b0};
    total++;
    if ({fome, felicidade, sono, morreu} !== exp_v) begin
      bad++;
      $display("FAIL reset_first_tick got=%h want=%h", {fome, felicidade, sono, morreu}, exp_v);
    end
  endtask

  task automatic test_idle();
    logic [24:0] exp_v;
    estado = 4'd0;
    do_reset();
    run_ticks(10);
    exp_v = {8'h4A, 8'hB6, 8'h4A, 1'b0};
    total++;
    if ({fome, felicidade, sono, morreu} !== exp_v) begin
      bad++;
      $display("FAIL idle_10 got=%h want=%h", {fome, felicidade, sono, morreu}, exp_v);
    end
  endtask

  task automatic test_eating();
    logic [24:0] exp_v;
    estado = 4'd1;
    do_reset();
    run_ticks(8);
    exp_v = {8'h00, 8'hC0, 8'h48, 1'b0};
    total++;
    if ({fome, felicidade, sono, morreu} !== exp_v) begin
      bad++;
      $display("FAIL eat_8 got=%h want=%h", {fome, felicidade, sono, morreu}, exp_v);
    end
    run_ticks(1);
    exp_v = {8'h00, 8'hC0, 8'h49, 1'b0};
    total++;
    if ({fome, felicidade, sono, morreu} !== exp_v) begin
      bad++;
      $display("FAIL eat_9_clamp got=%h want=%h", {fome, felicidade, sono, morreu}, exp_v);
    end
  endtask

  task automatic test_playing();
    logic [24:0] exp_v;
    estado = 4'd2;
    do_reset();
    run_ticks(8);
    exp_v = {8'h50, 8'hFF, 8'h50, 1'b0};
    total++;
    if ({fome, felicidade, sono, morreu} !== exp_v) begin
      bad++;
      $display("FAIL play_8 got=%h want=%h", {fome, felicidade, sono, morreu}, exp_v);
    end
    run_ticks(87);
    exp_v = {8'hFE, 8'hFF, 8'hFE, 1'b0};
    total++;
    if ({fome, felicidade, sono, morreu} !== exp_v) begin
      bad++;
      $display("FAIL play_95 got=%h want=%h", {fome, felicidade, sono, morreu}, exp_v);
    end
    repeat (3) @(negedge clk);
    total++;
    if ({fome, felicidade, sono, morreu} !== exp_v) begin
      bad++;
      $display("FAIL play_tick96_cycle got=%h want=%h", {fome, felicidade, sono, morreu}, exp_v);
    end
    @(negedge clk);
    exp_v = {8'hFF, 8'hFF, 8'hFF, 1'b1};
    total++;
    if ({fome, felicidade, sono, morreu} !== exp_v) begin
      bad++;
      $display("FAIL play_death got=%h want=%h", {fome, felicidade, sono, morreu}, exp_v);
    end
    estado = 4'd1;
    run_ticks(3);
    total++;
    if ({fome, felicidade, sono, morreu} !== exp_v) begin
      bad++;
      $display("FAIL play_frozen got=%h want=%h", {fome, felicidade, sono, morreu}, exp_v);
    end
  endtask

  task automatic test_unused_code();
    logic [24:0] exp_v;
    estado = 4'hF;
    do_reset();
    run_ticks(3);
    exp_v = {8'h43, 8'hBD, 8'h43, 1'b0};
    total++;
    if ({fome, felicidade, sono, morreu} !== exp_v) begin
      bad++;
      $display("FAIL unused_code got=%h want=%h", {fome, felicidade, sono, morreu}, exp_v);
    end
  endtask

  task automatic test_glitch();
    logic [24:0] exp_v;
    estado = 4'd0;
    do_reset();
    for (int t = 0; t < 3; t++) begin
      estado = 4'd1;
      repeat (3) @(negedge clk);
      estado = 4'd0;
      @(negedge clk);
    end
    exp_v = {8'h43, 8'hBD, 8'h43, 1'b0};
    total++;
    if ({fome, felicidade, sono, morreu} !== exp_v) begin
      bad++;
      $display("FAIL glitch_ignored got=%h want=%h", {fome, felicidade, sono, morreu}, exp_v);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_v = {8'h40, 8'hC0, 8'h40, 1'b0};
    total++;
    if ({fome, felicidade, sono, morreu} !== exp_v) begin
      bad++;
      $display("FAIL reset_on_tick got=%h want=%h", {fome, felicidade, sono, morreu}, exp_v);
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst_n  = 1'b0;
    estado = 4'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_idle();
    test_eating();
    test_playing();
    test_unused_code();
    test_glitch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
